axis_packet_loopback: RTL and testbench
=======================================

# axis_packet_loopback

Store-and-forward AXI-Stream packet buffer that replaces the plain sync FIFO between `uart_packet_rx` and `uart_packet_tx` in UART loopback designs. Only complete packets are ever presented downstream. Packets that are oversized or overflow the buffer are dropped whole, never truncated. The block adds an optional per-packet data inversion, plus accepted-packet and dropped-packet counters for the debug bus.

## Interface
- `AXIS_TDATA_WIDTH`, default 8: data width in bits; must be a multiple of 8.
- `AXIS_FIFO_DEPTH`, default 256: buffer depth in beats; must be a power of two, at least 2.
- `MAX_PACKET_LEN`, default 16: maximum beats per packet; must be between 1 and `AXIS_FIFO_DEPTH`.
- `DROP_ON_FULL`, default 1: 1 = input is always ready and full-buffer packets are dropped; 0 = backpressure on full.
- `COUNT_WIDTH`, default 16: width of each statistics counter.
- `i_clk`, in, 1: single clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_s_axis_tvalid` / `o_s_axis_tready`, in / out, 1 each: input handshake.
- `i_s_axis_tdata`, in, `AXIS_TDATA_WIDTH`: input data.
- `i_s_axis_tkeep`, in, `AXIS_TDATA_WIDTH/8`: input byte qualifiers.
- `i_s_axis_tlast`, in, 1: input end of packet.
- `o_m_axis_tvalid` / `i_m_axis_tready`, out / in, 1 each: output handshake.
- `o_m_axis_tdata`, `o_m_axis_tkeep`, `o_m_axis_tlast`, out: output beat, same widths as the input.
- `i_invert`, in, 1: invert the data of the next packet to start on the output.
- `o_pkt_count`, out, `COUNT_WIDTH`: packets committed to the buffer; wraps.
- `o_drop_count`, out, `COUNT_WIDTH`: packets dropped; wraps.
- `o_fill_level`, out, `$clog2(AXIS_FIFO_DEPTH)+1`: committed beats not yet read.

## Operation
- Storage: each word holds `{tlast, tkeep, tdata}`.
- Pointers are `ADDR_W+1` bits wide. There are three: `wr_ptr` (speculative), `commit_ptr` and `rd_ptr`.
- Full is `wr_ptr - rd_ptr == AXIS_FIFO_DEPTH`. Empty (for output) is `rd_ptr == commit_ptr`.
- Write FSM states: `WR_IDLE`, `WR_RECV`, `WR_DROP`.
- `WR_IDLE` / `WR_RECV`, accepted beat, good case: the beat is written at `wr_ptr` and `wr_ptr` increments.
  - If `tlast` is set, `commit_ptr <= wr_ptr+1`, `o_pkt_count` increments, and the FSM goes to `WR_IDLE`.
  - If `tlast` is clear, the FSM goes to `WR_RECV`.
- Drop conditions, evaluated on an accepted beat:
  - The beat would be beat number `MAX_PACKET_LEN+1`.
  - The buffer is full and `DROP_ON_FULL=1`.
- Drop action: the beat is not written and `wr_ptr <= commit_ptr` (rewind). The FSM goes to `WR_DROP`, unless the beat carries `tlast`, in which case it goes to `WR_IDLE`. `o_drop_count` increments once per dropped packet.
- `WR_DROP`: beats are accepted and discarded until `tlast`, then the FSM returns to `WR_IDLE`.
- `o_s_axis_tready`:
  - 1 in `WR_DROP`.
  - 1 when `DROP_ON_FULL=1`.
  - Otherwise `!full`.
- Read side: a one-deep output register is prefetched from the RAM (one-cycle read latency). It refills when empty or when it is being consumed, so a back-to-back stream runs at one beat per cycle.
- Inversion: `i_invert` is sampled when the first beat of a packet loads into the output register and is held until that packet's `tlast` leaves. When held, `o_m_axis_tdata = ~stored data`; `tkeep` and `tlast` are unaffected.
- AXIS rules: once `o_m_axis_tvalid` is high, it and the beat stay stable until `i_m_axis_tready`.
- Simultaneous events:
  - A commit and a read in the same cycle are both honoured.
  - A rewind never moves `wr_ptr` below `commit_ptr`.
  - Full is computed from `rd_ptr` before any same-cycle read, so it is conservative.
- Reset mid-packet: all pointers return to 0 and any partial or unread data is lost. Counters clear.

## Timing
- Reset values: `o_s_axis_tready=1`; `o_m_axis_tvalid=0`; `o_m_axis_tdata`, `o_m_axis_tkeep`, `o_m_axis_tlast=0`; counters and `o_fill_level=0`; FSM in `WR_IDLE`.
- `tlast` accepted in cycle N: `commit_ptr` and `o_pkt_count` update at N+1, and the first beat has `o_m_axis_tvalid` high at N+2 if the buffer was empty.
- `o_fill_level` is registered and reflects `commit_ptr - rd_ptr` one cycle after the change.
- `o_drop_count` updates the cycle after the offending beat.

## Structure
- Package `axis_loopback_pkg` holds:
  - the write FSM state typedef `wr_state_t`;
  - a helper function computing `ADDR_W`;
  - the packed storage word type built from the width parameters.
- Sub-module `sdp_ram` is a simple dual-port RAM with a registered read and one write port. It is sized `AXIS_FIFO_DEPTH` × `(AXIS_TDATA_WIDTH + AXIS_TDATA_WIDTH/8 + 1)`.

## Test plan
- Four-beat packet `0x11,0x22,0x33,0x44` with the output always ready: output identical, `tlast` on `0x44`, first beat valid 2 cycles after input `tlast`, `o_pkt_count=1`.
- 17-beat packet, then a 3-beat packet, with `MAX_PACKET_LEN=16`: only the 3-beat packet appears on the output; `o_drop_count=1`, `o_pkt_count=1`.
- `AXIS_FIFO_DEPTH=8`, output stalled, `DROP_ON_FULL=1`, two 5-beat packets: second is dropped, `o_fill_level=5`. Then release the output: only the first packet emerges.
- Same scenario with `DROP_ON_FULL=0`: `o_s_axis_tready` falls after 8 beats. Release the output: both packets emerge intact, with no drops.
- `i_invert=1` at the first output beat of packet `0xA5,0x0F`, cleared mid-packet: output `0x5A,0xF0`; the next packet is not inverted.
- Assert `i_rst_n` low after 2 beats of a 4-beat packet: all outputs return to reset values immediately. A following 1-beat packet passes normally.

Source files
------------

// File: rtl/axis_loopback_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet buffer.
package axis_loopback_pkg;

    // Write-side packet FSM: waiting for a packet, receiving one, or discarding one.
    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_RECV = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

    // Ceiling log2; gives the RAM address width for a power-of-two depth.
    function automatic int calc_addr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Width of one stored word {tlast, tkeep, tdata}.
    function automatic int word_width(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    // Storage word for the default 8-bit configuration.
    localparam int DEF_TDATA_WIDTH = 8;
    localparam int DEF_TKEEP_WIDTH = DEF_TDATA_WIDTH / 8;

    typedef struct packed {
        logic                       tlast;
        logic [DEF_TKEEP_WIDTH-1:0] tkeep;
        logic [DEF_TDATA_WIDTH-1:0] tdata;
    } axis_word_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// The read register holds its value while re_i is low, so it doubles as the
// output holding register of the packet buffer.
module sdp_ram #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port; no reset so the array maps to block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_packet_loopback.sv
// Store-and-forward AXI-Stream packet buffer. Beats are written speculatively
// and only become visible downstream once the packet's tlast commits it.
// Oversized packets, and packets meeting a full buffer in drop mode, are
// discarded whole by rewinding the write pointer to the last commit point.
module axis_packet_loopback
    import axis_loopback_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 8,
    parameter int AXIS_FIFO_DEPTH  = 256,
    parameter int MAX_PACKET_LEN   = 16,
    parameter int DROP_ON_FULL     = 1,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_s_axis_tvalid,
    output logic                              o_s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]       i_s_axis_tdata,
    input  logic [AXIS_TDATA_WIDTH/8-1:0]     i_s_axis_tkeep,
    input  logic                              i_s_axis_tlast,
    output logic                              o_m_axis_tvalid,
    input  logic                              i_m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]       o_m_axis_tdata,
    output logic [AXIS_TDATA_WIDTH/8-1:0]     o_m_axis_tkeep,
    output logic                              o_m_axis_tlast,
    input  logic                              i_invert,
    output logic [COUNT_WIDTH-1:0]            o_pkt_count,
    output logic [COUNT_WIDTH-1:0]            o_drop_count,
    output logic [$clog2(AXIS_FIFO_DEPTH):0]  o_fill_level
);

    localparam int DATA_W = AXIS_TDATA_WIDTH;
    localparam int KEEP_W = AXIS_TDATA_WIDTH / 8;
    localparam int ADDR_W = calc_addr_w(AXIS_FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int WORD_W = word_width(AXIS_TDATA_WIDTH);
    localparam int BEAT_W = calc_addr_w(MAX_PACKET_LEN + 1);

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } word_t;

    // Write side
    wr_state_t          state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   commit_ptr_q, commit_ptr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [COUNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic               full;
    logic               s_ready;
    logic               accept;
    logic               drop_beat;
    logic               ram_we;
    word_t              wr_word;

    // Read side
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   fetch_ptr;
    logic [PTR_W-1:0]   fill_q;
    logic               out_valid_q, out_valid_d;
    logic               inv_q, inv_d;
    logic               prev_last_q, prev_last_d;
    logic               have_data;
    logic               pop;
    logic               load;
    logic               is_first;
    logic [WORD_W-1:0]  ram_rdata;
    word_t              rd_word;

    // rd_ptr only advances when downstream takes a beat, so the word held in
    // the output register still counts as occupying its slot.
    assign full      = (wr_ptr_q - rd_ptr_q) == PTR_W'(AXIS_FIFO_DEPTH);
    assign s_ready   = (state_q == WR_DROP) || (DROP_ON_FULL != 0) || !full;
    assign accept    = i_s_axis_tvalid && s_ready;
    assign drop_beat = (beat_cnt_q == BEAT_W'(MAX_PACKET_LEN)) || ((DROP_ON_FULL != 0) && full);
    assign wr_word   = '{last: i_s_axis_tlast, keep: i_s_axis_tkeep, data: i_s_axis_tdata};

    // Write FSM: store good beats speculatively, commit on tlast, rewind on drop.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        ram_we       = 1'b0;
        if (accept) begin
            unique case (state_q)
                WR_IDLE, WR_RECV: begin
                    if (drop_beat) begin
                        wr_ptr_d   = commit_ptr_q;
                        beat_cnt_d = '0;
                        drop_cnt_d = drop_cnt_q + 1'b1;
                        state_d    = i_s_axis_tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (i_s_axis_tlast) begin
                            commit_ptr_d = wr_ptr_q + 1'b1;
                            pkt_cnt_d    = pkt_cnt_q + 1'b1;
                            beat_cnt_d   = '0;
                            state_d      = WR_IDLE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                            state_d    = WR_RECV;
                        end
                    end
                end
                WR_DROP: begin
                    if (i_s_axis_tlast) begin
                        state_d = WR_IDLE;
                    end
                end
                default: state_d = WR_IDLE;
            endcase
        end
    end

    // Write-side state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            beat_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Read side: prefetch the next committed word into the RAM read register
    // whenever the output is empty or being consumed this cycle.
    always_comb begin
        fetch_ptr   = rd_ptr_q + PTR_W'(out_valid_q);
        have_data   = fetch_ptr != commit_ptr_q;
        pop         = out_valid_q && i_m_axis_tready;
        load        = have_data && (!out_valid_q || i_m_axis_tready);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        out_valid_d = load || (out_valid_q && !pop);
        // The word being loaded starts a packet if the word before it ended one.
        is_first    = out_valid_q ? rd_word.last : prev_last_q;
        inv_d       = (load && is_first) ? i_invert : inv_q;
        prev_last_d = pop ? rd_word.last : prev_last_q;
    end

    // Read-side state registers and the registered fill level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            inv_q       <= 1'b0;
            prev_last_q <= 1'b1;
            fill_q      <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            inv_q       <= inv_d;
            prev_last_q <= prev_last_d;
            fill_q      <= commit_ptr_q - rd_ptr_q;
        end
    end

    sdp_ram #(
        .DEPTH  (AXIS_FIFO_DEPTH),
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_word),
        .re_i    (load),
        .raddr_i (fetch_ptr[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign rd_word = ram_rdata;

    // The RAM read register has no reset, so outputs are forced to zero while
    // nothing valid is presented.
    assign o_s_axis_tready = s_ready;
    assign o_m_axis_tvalid = out_valid_q;
    assign o_m_axis_tdata  = out_valid_q ? (rd_word.data ^ {DATA_W{inv_q}}) : '0;
    assign o_m_axis_tkeep  = out_valid_q ? rd_word.keep : '0;
    assign o_m_axis_tlast  = out_valid_q && rd_word.last;
    assign o_pkt_count     = pkt_cnt_q;
    assign o_drop_count    = drop_cnt_q;
    assign o_fill_level    = fill_q;

endmodule

// File: tb/tb_axis_packet_loopback.sv
// Bench for axis_packet_loopback. Three instances cover the default
// configuration and an 8-deep buffer in drop and backpressure modes.
// Stimulus pushes expected output beats into per-instance queues; a monitor
// pops and compares on every output handshake.
module tb_axis_packet_loopback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [3];
    logic        s_valid [3];
    logic        s_ready [3];
    logic [7:0]  s_data  [3];
    logic        s_keep  [3];
    logic        s_last  [3];
    logic        m_valid [3];
    logic        m_ready [3];
    logic [7:0]  m_data  [3];
    logic        m_keep  [3];
    logic        m_last  [3];
    logic        invert  [3];
    logic [15:0] pkt_cnt [3];
    logic [15:0] drop_cnt[3];
    logic [8:0]  fill0;
    logic [3:0]  fill1;
    logic [3:0]  fill2;

    int checks   = 0;
    int failures = 0;
    int acc_beats[3];

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    axis_packet_loopback #(
        .AXIS_TDATA_WIDTH(8), .AXIS_FIFO_DEPTH(256), .MAX_PACKET_LEN(16),
        .DROP_ON_FULL(1), .COUNT_WIDTH(16)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]),
        .i_s_axis_tvalid(s_valid[0]), .o_s_axis_tready(s_ready[0]),
        .i_s_axis_tdata(s_data[0]), .i_s_axis_tkeep(s_keep[0]), .i_s_axis_tlast(s_last[0]),
        .o_m_axis_tvalid(m_valid[0]), .i_m_axis_tready(m_ready[0]),
        .o_m_axis_tdata(m_data[0]), .o_m_axis_tkeep(m_keep[0]), .o_m_axis_tlast(m_last[0]),
        .i_invert(invert[0]), .o_pkt_count(pkt_cnt[0]), .o_drop_count(drop_cnt[0]),
        .o_fill_level(fill0)
    );

    axis_packet_loopback #(
        .AXIS_TDATA_WIDTH(8), .AXIS_FIFO_DEPTH(8), .MAX_PACKET_LEN(8),
        .DROP_ON_FULL(1), .COUNT_WIDTH(16)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]),
        .i_s_axis_tvalid(s_valid[1]), .o_s_axis_tready(s_ready[1]),
        .i_s_axis_tdata(s_data[1]), .i_s_axis_tkeep(s_keep[1]), .i_s_axis_tlast(s_last[1]),
        .o_m_axis_tvalid(m_valid[1]), .i_m_axis_tready(m_ready[1]),
        .o_m_axis_tdata(m_data[1]), .o_m_axis_tkeep(m_keep[1]), .o_m_axis_tlast(m_last[1]),
        .i_invert(invert[1]), .o_pkt_count(pkt_cnt[1]), .o_drop_count(drop_cnt[1]),
        .o_fill_level(fill1)
    );

    axis_packet_loopback #(
        .AXIS_TDATA_WIDTH(8), .AXIS_FIFO_DEPTH(8), .MAX_PACKET_LEN(8),
        .DROP_ON_FULL(0), .COUNT_WIDTH(16)
    ) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n[2]),
        .i_s_axis_tvalid(s_valid[2]), .o_s_axis_tready(s_ready[2]),
        .i_s_axis_tdata(s_data[2]), .i_s_axis_tkeep(s_keep[2]), .i_s_axis_tlast(s_last[2]),
        .o_m_axis_tvalid(m_valid[2]), .i_m_axis_tready(m_ready[2]),
        .o_m_axis_tdata(m_data[2]), .o_m_axis_tkeep(m_keep[2]), .o_m_axis_tlast(m_last[2]),
        .i_invert(invert[2]), .o_pkt_count(pkt_cnt[2]), .o_drop_count(drop_cnt[2]),
        .o_fill_level(fill2)
    );

    function automatic int get_fill(input int idx);
        case (idx)
            0:       return int'(fill0);
            1:       return int'(fill1);
            default: return int'(fill2);
        endcase
    endfunction

    function automatic int q_size(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void push_exp(input int idx, input logic [9:0] v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic bit pop_exp(input int idx, output logic [9:0] v);
        v = '0;
        case (idx)
            0:       if (q0.size() > 0) begin v = q0.pop_front(); return 1'b1; end
            1:       if (q1.size() > 0) begin v = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: one line per output beat, compared against the queue head.
    always @(negedge clk) begin : monitor
        logic [9:0] got;
        logic [9:0] exp_v;
        bit         have;
        for (int i = 0; i < 3; i++) begin
            if (rst_n[i] && m_valid[i] && m_ready[i]) begin
                got  = {m_last[i], m_keep[i], m_data[i]};
                have = pop_exp(i, exp_v);
                checks++;
                if (!have) begin
                    failures++;
                    $display("FAIL unexpected_beat inst%0d actual=0x%03h required=none", i, got);
                end else if (got !== exp_v) begin
                    failures++;
                    $display("FAIL out_beat inst%0d actual=0x%03h required=0x%03h", i, got, exp_v);
                end else begin
                    $display("inst%0d out data=0x%02h keep=%b last=%b", i, m_data[i], m_keep[i], m_last[i]);
                end
            end
        end
    end

    // Drives one packet; data runs base, base+step, ... (mod 256). Expected
    // beats are queued only when the packet should reach the output.
    task automatic send_pkt(input int idx, input logic [7:0] base, input logic [7:0] step,
                            input int len, input bit exp_out, input bit exp_inv, input bit with_last);
        logic [7:0] d;
        bit         lst;
        bit         acc;
        int         n;
        d = base;
        for (int b = 0; b < len; b++) begin
            lst = with_last && (b == len - 1);
            if (exp_out) push_exp(idx, {lst, 1'b1, exp_inv ? ~d : d});
            s_valid[idx] = 1'b1;
            s_data[idx]  = d;
            s_keep[idx]  = 1'b1;
            s_last[idx]  = lst;
            n   = 0;
            acc = 1'b0;
            while (!acc && n < 500) begin
                @(negedge clk);
                acc = s_ready[idx];
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout inst%0d actual=not_accepted required=accepted", idx);
            end else begin
                acc_beats[idx]++;
            end
            d = d + step;
        end
        s_valid[idx] = 1'b0;
        s_last[idx]  = 1'b0;
    endtask

    task automatic drain(input int idx);
        int n;
        n = 0;
        while (q_size(idx) != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", q_size(idx), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset(input int idx);
        rst_n[idx] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[idx] = 1'b1;
        acc_beats[idx] = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        for (int i = 0; i < 3; i++) begin
            rst_n[i]   = 1'b0;
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            s_keep[i]  = 1'b0;
            s_last[i]  = 1'b0;
            m_ready[i] = 1'b0;
            invert[i]  = 1'b0;
            acc_beats[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(posedge clk);
        #1;

        // Reset state of every instance
        for (int i = 0; i < 3; i++) begin
            check("rst_tready", s_ready[i], 1);
            check("rst_tvalid", m_valid[i], 0);
            check("rst_tdata", m_data[i], 0);
            check("rst_pkt_count", pkt_cnt[i], 0);
            check("rst_drop_count", drop_cnt[i], 0);
            check("rst_fill", get_fill(i), 0);
        end

        // Four-beat packet, output always ready, with first-beat latency
        m_ready[0] = 1'b1;
        send_pkt(0, 8'h11, 8'h11, 4, 1'b1, 1'b0, 1'b1);
        check("t1_valid_n_plus_1", m_valid[0], 0);
        check("t1_pkt_count_n_plus_1", pkt_cnt[0], 1);
        @(posedge clk);
        #1;
        check("t1_valid_n_plus_2", m_valid[0], 1);
        check("t1_first_data", m_data[0], 8'h11);
        drain(0);
        check("t1_pkt_count", pkt_cnt[0], 1);
        check("t1_fill_after", get_fill(0), 0);

        // Oversized 17-beat packet dropped, 3-beat packet passes
        pulse_reset(0);
        send_pkt(0, 8'h01, 8'h01, 17, 1'b0, 1'b0, 1'b1);
        check("t2_drop_next_cycle", drop_cnt[0], 1);
        send_pkt(0, 8'hB0, 8'h01, 3, 1'b1, 1'b0, 1'b1);
        drain(0);
        check("t2_drop_count", drop_cnt[0], 1);
        check("t2_pkt_count", pkt_cnt[0], 1);

        // Inversion sampled at first output beat, held across the packet
        pulse_reset(0);
        m_ready[0] = 1'b0;
        invert[0]  = 1'b1;
        send_pkt(0, 8'hA5, 8'h6A, 2, 1'b1, 1'b1, 1'b1);
        n = 0;
        while (!m_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
        check("t5_first_loaded", m_valid[0], 1);
        invert[0] = 1'b0;
        @(posedge clk);
        #1;
        check("t5_held_data", m_data[0], 8'h5A);
        m_ready[0] = 1'b1;
        send_pkt(0, 8'h3C, 8'h87, 2, 1'b1, 1'b0, 1'b1);
        drain(0);

        // Reset in the middle of a packet with a committed beat pending
        pulse_reset(0);
        m_ready[0] = 1'b0;
        send_pkt(0, 8'h77, 8'h00, 1, 1'b0, 1'b0, 1'b1);
        send_pkt(0, 8'h10, 8'h10, 2, 1'b0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("t6_pre_valid", m_valid[0], 1);
        check("t6_pre_pkt_count", pkt_cnt[0], 1);
        check("t6_pre_fill", get_fill(0), 1);
        rst_n[0] = 1'b0;
        #1;
        check("t6_rst_tready", s_ready[0], 1);
        check("t6_rst_tvalid", m_valid[0], 0);
        check("t6_rst_tdata", m_data[0], 0);
        check("t6_rst_tlast", m_last[0], 0);
        check("t6_rst_tkeep", m_keep[0], 0);
        check("t6_rst_pkt_count", pkt_cnt[0], 0);
        check("t6_rst_fill", get_fill(0), 0);
        @(posedge clk);
        #1;
        rst_n[0]   = 1'b1;
        m_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(0, 8'h99, 8'h00, 1, 1'b1, 1'b0, 1'b1);
        drain(0);
        check("t6_post_pkt_count", pkt_cnt[0], 1);

        // Depth 8, drop on full: second 5-beat packet dropped while stalled
        send_pkt(1, 8'h40, 8'h01, 5, 1'b1, 1'b0, 1'b1);
        send_pkt(1, 8'h50, 8'h01, 5, 1'b0, 1'b0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        check("t3_fill", get_fill(1), 5);
        check("t3_drop_count", drop_cnt[1], 1);
        check("t3_pkt_count", pkt_cnt[1], 1);
        check("t3_tready", s_ready[1], 1);
        m_ready[1] = 1'b1;
        drain(1);
        check("t3_fill_after", get_fill(1), 0);

        // Depth 8, backpressure: tready falls after 8 beats, both packets survive
        send_pkt(2, 8'h60, 8'h01, 5, 1'b1, 1'b0, 1'b1);
        fork
            send_pkt(2, 8'h70, 8'h01, 5, 1'b1, 1'b0, 1'b1);
            begin
                repeat (30) begin @(posedge clk); #1; end
                check("t4_tready_low", s_ready[2], 0);
                check("t4_beats_accepted", acc_beats[2], 8);
                check("t4_fill", get_fill(2), 5);
                m_ready[2] = 1'b1;
            end
        join
        drain(2);
        check("t4_drop_count", drop_cnt[2], 0);
        check("t4_pkt_count", pkt_cnt[2], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
